// File: rtl/sprite_motion_ctrl.sv
// Per-frame player sprite motion: walking with screen clamp, jump FSM with integer gravity.
// Latency: all outputs registered, valid one cycle after the i_frame cycle, held until the next pulse.
// Backpressure: none; inputs are level samples taken only in the i_frame cycle.
//
// Ports: i_clk_pix/i_rst_n (sync, active-low), i_frame pulse, debounced button levels in;
//        o_sprx/o_spry signed sprite top-left, o_face_left, o_walking, o_jumping out.
module sprite_motion_ctrl #(
  parameter int CORDW      = 16,
  parameter int H_RES      = 800,
  parameter int SPR_W      = 38,
  parameter int GROUND_Y   = 480,
  parameter int START_X    = 100,
  parameter int WALK_SPEED = 3,
  parameter int JUMP_VEL   = 12,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL   = 12
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic                    i_btn_left,
  input  logic                    i_btn_right,
  input  logic                    i_btn_jump,
  output logic signed [CORDW-1:0] o_sprx,
  output logic signed [CORDW-1:0] o_spry,
  output logic                    o_face_left,
  output logic                    o_walking,
  output logic                    o_jumping
);

  localparam int W1 = CORDW + 1;

  // Intermediates are one bit wider than the stored coordinates so no sum can wrap.
  localparam logic signed [W1-1:0] X_MAX_W = W1'(H_RES - SPR_W);
  localparam logic signed [W1-1:0] STEP_W  = W1'(WALK_SPEED);
  localparam logic signed [W1-1:0] GND_W   = W1'(GROUND_Y);
  localparam logic signed [W1-1:0] Y_MIN_W = W1'(-(2 ** (CORDW - 1)));
  localparam logic [W1-1:0]        GRAV_W  = W1'(GRAVITY);
  localparam logic [W1-1:0]        MAXF_W  = W1'(MAX_FALL);

  localparam logic [CORDW-1:0]        VY_JUMP = CORDW'(JUMP_VEL);
  localparam logic [CORDW-1:0]        VY_GRAV = CORDW'(GRAVITY);
  localparam logic [CORDW-1:0]        VY_MAXF = CORDW'(MAX_FALL);
  localparam logic signed [CORDW-1:0] X_START = CORDW'(START_X);
  localparam logic signed [CORDW-1:0] Y_GND   = CORDW'(GROUND_Y);

  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL} state_t;

  state_t                  state_q, state_d;
  logic signed [CORDW-1:0] x_q, x_d;
  logic signed [CORDW-1:0] y_q, y_d;
  logic [CORDW-1:0]        vy_q, vy_d;
  logic                    face_q, face_d;
  logic                    walking_q, walking_d;
  logic                    jumping_q, jumping_d;
  logic                    jump_prev_q, jump_prev_d;

  logic                    dir_left, dir_right, jump_edge;
  logic signed [W1-1:0]    x_ext, x_cand, x_clamp;
  logic signed [W1-1:0]    y_ext, vy_ext, y_rise, y_fall;
  logic [W1-1:0]           nvy_sum;
  logic [CORDW-1:0]        nvy;

  assign dir_left  = i_btn_left & ~i_btn_right;
  assign dir_right = i_btn_right & ~i_btn_left;
  assign jump_edge = i_btn_jump & ~jump_prev_q;

  // Horizontal candidate and clamp to [0, H_RES-SPR_W]
  always_comb begin
    x_ext = {x_q[CORDW-1], x_q};
    x_cand = x_ext;
    if (dir_left) begin
      x_cand = x_ext - STEP_W;
    end else if (dir_right) begin
      x_cand = x_ext + STEP_W;
    end
    x_clamp = x_cand;
    if (x_cand[W1-1]) begin
      x_clamp = '0;
    end else if (x_cand > X_MAX_W) begin
      x_clamp = X_MAX_W;
    end
  end

  // State register (with datapath flops)
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_q     <= ST_GROUND;
      x_q         <= X_START;
      y_q         <= Y_GND;
      vy_q        <= '0;
      face_q      <= 1'b0;
      walking_q   <= 1'b0;
      jumping_q   <= 1'b0;
      // A button already held through reset must not launch a jump.
      jump_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      face_q      <= face_d;
      walking_q   <= walking_d;
      jumping_q   <= jumping_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  // Next state: jump FSM with vertical position and velocity magnitude
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
    y_ext   = {y_q[CORDW-1], y_q};
    vy_ext  = signed'({1'b0, vy_q});
    y_rise  = y_ext - vy_ext;
    nvy_sum = {1'b0, vy_q} + GRAV_W;
    nvy     = (nvy_sum > MAXF_W) ? VY_MAXF : nvy_sum[CORDW-1:0];
    y_fall  = y_ext + signed'({1'b0, nvy});
    if (i_frame) begin
      case (state_q)
        ST_GROUND: begin
          if (jump_edge) begin
            vy_d    = VY_JUMP;
            state_d = ST_RISE;
          end else begin
            y_d = Y_GND;
          end
        end
        ST_RISE: begin
          y_d = (y_rise < Y_MIN_W) ? Y_MIN_W[CORDW-1:0] : y_rise[CORDW-1:0];
          if (vy_q <= VY_GRAV) begin
            vy_d    = '0;
            state_d = ST_FALL;
          end else begin
            vy_d = vy_q - VY_GRAV;
          end
        end
        ST_FALL: begin
          if (y_fall >= GND_W) begin
            y_d     = Y_GND;
            vy_d    = '0;
            state_d = ST_GROUND;
          end else begin
            y_d  = y_fall[CORDW-1:0];
            vy_d = nvy;
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  // Outputs: x, facing and animation flags, all judged against the next state
  always_comb begin
    x_d         = x_q;
    face_d      = face_q;
    walking_d   = walking_q;
    jumping_d   = jumping_q;
    jump_prev_d = jump_prev_q;
    if (i_frame) begin
      x_d         = x_clamp[CORDW-1:0];
      jump_prev_d = i_btn_jump;
      if (dir_left) begin
        face_d = 1'b1;
      end else if (dir_right) begin
        face_d = 1'b0;
      end
      jumping_d = (state_d != ST_GROUND);
      // Pushing into a wall does not animate walking.
      walking_d = (state_d == ST_GROUND) && (dir_left || dir_right) && (x_clamp != x_ext);
    end
  end

  assign o_sprx      = x_q;
  assign o_spry      = y_q;
  assign o_face_left = face_q;
  assign o_walking   = walking_q;
  assign o_jumping   = jumping_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  localparam int GY = 480;
  localparam int XMAX = 762;
  localparam int SPD = 3;
  localparam int JV = 12;
  localparam int GR = 1;
  localparam int MF = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, frame = 1'b0, bl = 1'b0, br = 1'b0, bj = 1'b0;
  logic signed [15:0] sprx, spry;
  logic face, walk, jmp;

  sprite_motion_ctrl dut (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame),
    .i_btn_left(bl), .i_btn_right(br), .i_btn_jump(bj),
    .o_sprx(sprx), .o_spry(spry), .o_face_left(face),
    .o_walking(walk), .o_jumping(jmp)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a jump precomputes its whole y trajectory into a queue,
  // which is then consumed one entry per frame while airborne.
  int m_x, m_y, m_face, m_walk, m_jump, m_prev;
  int traj[$];

  function automatic void build_traj();
    int v, yy, nv;
    v = JV;
    yy = GY;
    traj.delete();
    while (1) begin
      yy = yy - v;
      traj.push_back(yy);
      if (v <= GR) begin v = 0; break; end
      v = v - GR;
    end
    while (1) begin
      nv = (v + GR > MF) ? MF : v + GR;
      if (yy + nv >= GY) begin traj.push_back(GY); break; end
      yy = yy + nv;
      traj.push_back(yy);
      v = nv;
    end
  endfunction

  function automatic void m_step(input bit r, input bit f, input bit l, input bit rt, input bit j);
    int dir, nx;
    if (!r) begin
      m_x = 100; m_y = GY; m_face = 0; m_walk = 0; m_jump = 0; m_prev = 1;
      traj.delete();
    end else if (f) begin
      dir = (l && !rt) ? -1 : ((rt && !l) ? 1 : 0);
      nx = m_x + dir * SPD;
      if (nx < 0) nx = 0;
      if (nx > XMAX) nx = XMAX;
      if (dir == -1) m_face = 1;
      if (dir == 1) m_face = 0;
      if (traj.size() > 0) m_y = traj.pop_front();
      else if (j && !m_prev) build_traj();
      else m_y = GY;
      m_jump = (traj.size() > 0) ? 1 : 0;
      m_walk = (m_jump == 0 && dir != 0 && nx != m_x) ? 1 : 0;
      m_x = nx;
      m_prev = j;
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check5(input string tag, input int ex, input int ey, input int ef, input int ew, input int ej);
    chk({tag, ".x"}, int'(sprx), ex);
    chk({tag, ".y"}, int'(spry), ey);
    chk({tag, ".face"}, int'(face), ef);
    chk({tag, ".walk"}, int'(walk), ew);
    chk({tag, ".jump"}, int'(jmp), ej);
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic cyc(input bit r, input bit f, input bit l, input bit rt, input bit j);
    rst_n = r; frame = f; bl = l; br = rt; bj = j;
    @(posedge clk);
    #1;
    frame = 1'b0;
    m_step(r, f, l, rt, j);
  endtask

  typedef struct {
    bit r, f, l, rt, j;
    int x, y, fc, wk, jp;
  } vec_t;
  vec_t tbl[16];

  int ys[25] = '{480, 468, 457, 447, 438, 430, 423, 417, 412, 408, 405, 403, 402,
                 403, 405, 408, 412, 417, 423, 430, 438, 447, 457, 468, 480};

  initial begin
    //          r f l r j   x    y   fc wk jp
    tbl[0]  = '{0,1,0,0,0, 100, 480, 0, 0, 0};  // reset
    tbl[1]  = '{1,1,0,0,0, 100, 480, 0, 0, 0};  // idle
    tbl[2]  = '{1,1,0,0,0, 100, 480, 0, 0, 0};
    tbl[3]  = '{1,1,0,1,0, 103, 480, 0, 1, 0};  // walk right
    tbl[4]  = '{1,1,0,1,0, 106, 480, 0, 1, 0};
    tbl[5]  = '{1,1,1,0,0, 103, 480, 1, 1, 0};  // walk left
    tbl[6]  = '{1,1,1,1,0, 103, 480, 1, 0, 0};  // both: no move, face kept
    tbl[7]  = '{1,1,0,0,0, 103, 480, 1, 0, 0};
    tbl[8]  = '{1,0,0,1,1, 103, 480, 1, 0, 0};  // no frame: ignored
    tbl[9]  = '{1,1,0,0,1, 103, 480, 1, 0, 1};  // launch
    tbl[10] = '{1,1,0,0,1, 103, 468, 1, 0, 1};
    tbl[11] = '{1,1,0,0,0, 103, 457, 1, 0, 1};
    tbl[12] = '{0,1,0,0,1, 100, 480, 0, 0, 0};  // reset mid-jump wins over frame
    tbl[13] = '{1,1,0,0,1, 100, 480, 0, 0, 0};  // held through reset: no jump
    tbl[14] = '{1,1,0,0,0, 100, 480, 0, 0, 0};
    tbl[15] = '{1,1,0,0,1, 100, 480, 0, 0, 1};  // fresh edge launches

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].l, tbl[i].rt, tbl[i].j);
      check5($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].fc, tbl[i].wk, tbl[i].jp);
    end

    // Walk into the right wall
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 220; k++) cyc(1, 1, 0, 1, 0);
    check5("wall_760", 760, 480, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    check5("wall_762", 762, 480, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    check5("wall_push", 762, 480, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1, 0, 1);
      check5("gated", 762, 480, 0, 0, 0);
    end

    // Full jump with right held (air control) and jump held 40 frames
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 40; k++) begin
      cyc(1, 1, 0, 1, 1);
      check5($sformatf("held%0d", k), 100 + 3 * k, (k <= 25) ? ys[k-1] : 480, 0,
             (k >= 25) ? 1 : 0, (k <= 24) ? 1 : 0);
    end

    // Re-taps while airborne and in the landing frame are ignored; new edge jumps
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    for (int k = 1; k <= 28; k++) begin
      cyc(1, 1, 0, 0, (k % 2 == 1) || (k == 28));
      if (k <= 25)
        check5($sformatf("retap%0d", k), 100, ys[k-1], 0, 0, (k <= 24) ? 1 : 0);
      else if (k == 26)
        check5("retap26", 100, 480, 0, 0, 0);
      else
        check5($sformatf("retap%0d", k), 100, ys[k-27], 0, 0, 1);
    end

    // Randomised run against the reference model
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0);
      check5($sformatf("rnd%0d", k), m_x, m_y, m_face, m_walk, m_jump);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
